seq_divider: RTL

//   Iterative unsigned restoring divider; the responder side of the muldiv div/rem

---
 rtl/seq_divider_if.sv | 22 ++
 rtl/seq_divider.sv | 111 +++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// Start/response bundle between the muldiv caller and the iterative divider.
// The caller holds start high and the operands steady until it sees div_resp.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] numerator;
    logic [WIDTH-1:0] denominator;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_resp;

    modport master (
        output start, numerator, denominator,
        input  quotient, remainder, div_resp
    );

    modport slave (
        input  start, numerator, denominator,
        output quotient, remainder, div_resp
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider that resolves one quotient bit per clock.
// Handshake: an op is accepted only on an edge where state is IDLE and start=1.
// div_resp is high for exactly the one DONE cycle, and quotient/remainder are valid from then on.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    seq_divider_if.slave        bus,
    output logic [1:0]          dbg_state
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH:0]   p, p_n;
    logic [WIDTH-1:0] q, q_n;
    logic [WIDTH-1:0] d, d_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] quo, quo_n;
    logic [WIDTH-1:0] rem, rem_n;

    logic [WIDTH:0]   p_sh;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH+1:0] diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            p     <= '0;
            q     <= '0;
            d     <= '0;
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
        end else begin
            state <= state_n;
            p     <= p_n;
            q     <= q_n;
            d     <= d_n;
            cnt   <= cnt_n;
            quo   <= quo_n;
            rem   <= rem_n;
        end
    end

    always_comb begin
        state_n = state;
        p_n     = p;
        q_n     = q;
        d_n     = d;
        cnt_n   = cnt;
        quo_n   = quo;
        rem_n   = rem;

        // P < D holds between steps, so the shifted P fits in WIDTH+1 bits;
        // the extra top bit of diff is the borrow of the trial subtraction.
        p_sh = {p[WIDTH-1:0], q[WIDTH-1]};
        q_sh = {q[WIDTH-2:0], 1'b0};
        diff = {1'b0, p_sh} - {2'b00, d};

        case (state)
            IDLE: begin
                if (bus.start) begin
                    d_n = bus.denominator;
                    q_n = bus.numerator;
                    if (bus.denominator == '0) begin
                        quo_n   = '1;
                        rem_n   = bus.numerator;
                        state_n = DONE;
                    end else begin
                        p_n     = '0;
                        cnt_n   = '0;
                        state_n = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!diff[WIDTH+1]) begin
                    p_n = diff[WIDTH:0];
                    q_n = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    p_n = p_sh;
                    q_n = q_sh;
                end
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    quo_n   = q_n;
                    rem_n   = p_n[WIDTH-1:0];
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.quotient  = quo;
    assign bus.remainder = rem;
    assign bus.div_resp  = (state == DONE);
    assign dbg_state     = state;
endmodule
